// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I pipeline stage registers.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    NpcSeq    = 2'd0,
    NpcJal    = 2'd1,
    NpcJalr   = 2'd2,
    NpcBranch = 2'd3
  } next_pc_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus_4;
    logic [REG_AW-1:0] rd;
    logic              im_to_rf;
    logic              store;
    logic              load;
    next_pc_sel_e      next_pc_selector;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   uj_type;
    logic [XLEN-1:0]   alu_data;
    logic [XLEN-1:0]   jump_i_type;
    logic [XLEN-1:0]   jump_sb_type;
  } ex_mem_bundle_t;

  localparam int unsigned ExMemW = $bits(ex_mem_bundle_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with async reset, bubble (flush) and hold (stall).
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  // Flush outranks stall so a squashed instruction never lingers in the stage.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (!stall_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures all EX results as one bundle for the MEM stage.
module ex_mem_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   pc_ex,
  input  logic [XLEN-1:0]   pc_plus_4_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              im_to_rf_ex,
  input  logic              store_ex,
  input  logic              load_ex,
  input  logic [1:0]        next_pc_selector_ex,
  input  logic [XLEN-1:0]   rs2_data_ex,
  input  logic [XLEN-1:0]   uj_type_ex,
  input  logic [XLEN-1:0]   alu_data_ex,
  input  logic [XLEN-1:0]   jump_i_type_ex,
  input  logic [XLEN-1:0]   jump_sb_type_ex,
  output logic [XLEN-1:0]   pc_mem,
  output logic [XLEN-1:0]   pc_plus_4_mem,
  output logic [REG_AW-1:0] rd_mem,
  output logic              im_to_rf_mem,
  output logic              store_mem,
  output logic              load_mem,
  output logic [1:0]        next_pc_selector_mem,
  output logic [XLEN-1:0]   rs2_data_mem,
  output logic [XLEN-1:0]   uj_type_mem,
  output logic [XLEN-1:0]   alu_data_mem,
  output logic [XLEN-1:0]   jump_i_type_mem,
  output logic [XLEN-1:0]   jump_sb_type_mem
);

  ex_mem_bundle_t ex_b, mem_b;

  always_comb begin
    ex_b                  = '0;
    ex_b.pc               = pc_ex;
    ex_b.pc_plus_4        = pc_plus_4_ex;
    ex_b.rd               = rd_ex;
    ex_b.im_to_rf         = im_to_rf_ex;
    ex_b.store            = store_ex;
    ex_b.load             = load_ex;
    ex_b.next_pc_selector = next_pc_sel_e'(next_pc_selector_ex);
    ex_b.rs2_data         = rs2_data_ex;
    ex_b.uj_type          = uj_type_ex;
    ex_b.alu_data         = alu_data_ex;
    ex_b.jump_i_type      = jump_i_type_ex;
    ex_b.jump_sb_type     = jump_sb_type_ex;
  end

  pipe_reg #(
    .Width (ExMemW)
  ) u_pipe_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .stall_i (stall),
    .d_i     (ex_b),
    .q_o     (mem_b)
  );

  assign pc_mem               = mem_b.pc;
  assign pc_plus_4_mem        = mem_b.pc_plus_4;
  assign rd_mem               = mem_b.rd;
  assign im_to_rf_mem         = mem_b.im_to_rf;
  assign store_mem            = mem_b.store;
  assign load_mem             = mem_b.load;
  assign next_pc_selector_mem = mem_b.next_pc_selector;
  assign rs2_data_mem         = mem_b.rs2_data;
  assign uj_type_mem          = mem_b.uj_type;
  assign alu_data_mem         = mem_b.alu_data;
  assign jump_i_type_mem      = mem_b.jump_i_type;
  assign jump_sb_type_mem     = mem_b.jump_sb_type;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed and table-driven checks for the EX/MEM pipeline register.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        im;
    logic        store;
    logic        load;
    logic [1:0]  npc;
    logic [31:0] rs2;
    logic [31:0] uj;
    logic [31:0] alu;
    logic [31:0] ji;
    logic [31:0] jsb;
  } fields_t;

  typedef struct {
    logic    stall;
    logic    flush;
    fields_t in;
    fields_t exp;
  } vec_t;

  logic    clk, rst, stall, flush;
  fields_t in_f, out_f;
  int      total = 0;
  int      bad   = 0;

  ex_mem_reg u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .flush                (flush),
    .pc_ex                (in_f.pc),
    .pc_plus_4_ex         (in_f.pc4),
    .rd_ex                (in_f.rd),
    .im_to_rf_ex          (in_f.im),
    .store_ex             (in_f.store),
    .load_ex              (in_f.load),
    .next_pc_selector_ex  (in_f.npc),
    .rs2_data_ex          (in_f.rs2),
    .uj_type_ex           (in_f.uj),
    .alu_data_ex          (in_f.alu),
    .jump_i_type_ex       (in_f.ji),
    .jump_sb_type_ex      (in_f.jsb),
    .pc_mem               (out_f.pc),
    .pc_plus_4_mem        (out_f.pc4),
    .rd_mem               (out_f.rd),
    .im_to_rf_mem         (out_f.im),
    .store_mem            (out_f.store),
    .load_mem             (out_f.load),
    .next_pc_selector_mem (out_f.npc),
    .rs2_data_mem         (out_f.rs2),
    .uj_type_mem          (out_f.uj),
    .alu_data_mem         (out_f.alu),
    .jump_i_type_mem      (out_f.ji),
    .jump_sb_type_mem     (out_f.jsb)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic fields_t pat(input logic [31:0] s);
    fields_t f;
    f.pc    = s << 4;
    f.pc4   = (s << 4) + 32'd4;
    f.rd    = s[4:0];
    f.im    = s[0];
    f.store = s[1];
    f.load  = s[2];
    f.npc   = s[1:0];
    f.rs2   = s ^ 32'hA5A5_0000;
    f.uj    = s << 8;
    f.alu   = ~s;
    f.ji    = s + 32'h100;
    f.jsb   = s + 32'h200;
    return f;
  endfunction

  function automatic fields_t rnd();
    fields_t f;
    f.pc    = $urandom;
    f.pc4   = $urandom;
    f.rd    = 5'($urandom);
    f.im    = 1'($urandom);
    f.store = 1'($urandom);
    f.load  = 1'($urandom);
    f.npc   = 2'($urandom);
    f.rs2   = $urandom;
    f.uj    = $urandom;
    f.alu   = $urandom;
    f.ji    = $urandom;
    f.jsb   = $urandom;
    return f;
  endfunction

  task automatic check(input string name, input fields_t act, input fields_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t    vecs[9];
  fields_t pt, zero_f;

  initial begin
    zero_f = '0;
    vecs[0] = '{1'b0, 1'b0, pat(1), pat(1)};
    vecs[1] = '{1'b0, 1'b0, pat(2), pat(2)};
    vecs[2] = '{1'b1, 1'b0, pat(3), pat(2)};
    vecs[3] = '{1'b1, 1'b0, pat(4), pat(2)};
    vecs[4] = '{1'b0, 1'b0, pat(5), pat(5)};
    vecs[5] = '{1'b0, 1'b1, pat(6), zero_f};
    vecs[6] = '{1'b1, 1'b1, pat(7), zero_f};
    vecs[7] = '{1'b1, 1'b0, pat(8), zero_f};
    vecs[8] = '{1'b0, 1'b0, pat(9), pat(9)};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_f = pat(100);
    #5 check("reset_state", out_f, zero_f);
    @(negedge clk); rst = 1'b0;
    #1 check("rst_release_no_edge", out_f, zero_f);

    // Pass-through
    pt = '0;
    pt.pc = 32'h0000_1000; pt.pc4 = 32'h0000_1004; pt.rd = 5'd5;
    pt.load = 1'b1; pt.alu = 32'hDEAD_BEEF;
    in_f = pt;
    #1 check("pt_before_edge", out_f, zero_f);
    @(posedge clk); #1 check("pt_after_edge", out_f, pt);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      stall = vecs[i].stall; flush = vecs[i].flush; in_f = vecs[i].in;
      @(posedge clk); #1 check($sformatf("vec%0d", i), out_f, vecs[i].exp);
    end

    // Stall holds rd/alu across several cycles
    @(negedge clk); stall = 1'b0; flush = 1'b0;
    in_f = pat(20); in_f.rd = 5'd7; in_f.alu = 32'hCAFE_0001;
    @(posedge clk); #1 check32("stall_load_rd", 32'(out_f.rd), 32'd7);
    @(negedge clk); stall = 1'b1; in_f.rd = 5'd9; in_f.alu = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check32($sformatf("stall_rd_c%0d", i), 32'(out_f.rd), 32'd7);
      check32($sformatf("stall_alu_c%0d", i), out_f.alu, 32'hCAFE_0001);
    end
    @(negedge clk); stall = 1'b0;
    #1 check32("unstall_before_edge", 32'(out_f.rd), 32'd7);
    @(posedge clk); #1;
    check32("unstall_rd", 32'(out_f.rd), 32'd9);
    check32("unstall_alu", out_f.alu, 32'h0000_1234);

    // Flush with side-effecting fields set
    @(negedge clk);
    in_f = pat(21); in_f.store = 1'b1; in_f.npc = 2'd2; in_f.rd = 5'd3; flush = 1'b1;
    @(posedge clk); #1 check("flush_bubble", out_f, zero_f);
    @(negedge clk); flush = 1'b0;

    // Asynchronous reset mid-cycle
    in_f = pat(50);
    @(posedge clk); #1 check("pre_async_load", out_f, pat(50));
    #4 rst = 1'b1;
    #1 check("async_reset_mid_cycle", out_f, zero_f);
    @(posedge clk); #1 check("reset_held_over_edge", out_f, zero_f);
    @(negedge clk); rst = 1'b0;
    #1 check("reset_release_wait", out_f, zero_f);

    // Streaming: stimulus every 25 ns, never aligned to a clock edge
    @(negedge clk);
    fork
      begin
        #2;
        for (int k = 0; k < 5; k++) begin
          in_f = rnd();
          #25;
        end
      end
      begin
        fields_t exp_s;
        for (int k = 0; k < 7; k++) begin
          @(posedge clk);
          exp_s = in_f;
          #1 check($sformatf("stream%0d", k), out_f, exp_s);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the RV32I 5-stage pipelined CPU.
- Captures every EX-stage result and control signal on the rising clock edge and presents it to the MEM stage for one full cycle.
- Supports pipeline hold (stall) and bubble insertion (flush) from the hazard unit.

Parameters:
- XLEN, 32, data/address width of PC, immediates and data buses.
- REG_AW, 5, register-file index width (rd).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold current MEM-side contents.
- flush  in  1  load a bubble (all-zero) on next edge.
- pc_ex / pc_mem  in/out  XLEN  instruction PC.
- pc_plus_4_ex / pc_plus_4_mem  in/out  XLEN  PC+4 (JAL/JALR link value).
- rd_ex / rd_mem  in/out  REG_AW  destination register index.
- im_to_rf_ex / im_to_rf_mem  in/out  1  write immediate (U-type) to RF.
- store_ex / store_mem  in/out  1  store instruction.
- load_ex / load_mem  in/out  1  load instruction.
- next_pc_selector_ex / next_pc_selector_mem  in/out  2  next-PC mux select; 0 = sequential.
- rs2_data_ex / rs2_data_mem  in/out  XLEN  store data.
- uj_type_ex / uj_type_mem  in/out  XLEN  U/J-type immediate or target.
- alu_data_ex / alu_data_mem  in/out  XLEN  ALU result / memory address.
- jump_i_type_ex / jump_i_type_mem  in/out  XLEN  JALR target.
- jump_sb_type_ex / jump_sb_type_mem  in/out  XLEN  branch target.

Behaviour:
- Every *_mem output is a flop driven from its *_ex input. No combinational path from input to output.
- Latency: exactly 1 clock.
- rst high: all *_mem outputs go to 0 immediately, without waiting for clk, and stay 0 while rst is high.
- First capture after rst falls happens on the next rising edge.
- Priority at each rising edge: rst > flush > stall > normal load.
  - flush=1: all *_mem become 0 (bubble). rd=0, load=store=im_to_rf=0 and next_pc_selector=0, so the bubble has no side effects.
  - flush=0, stall=1: all *_mem keep their previous values.
  - Otherwise (normal load): *_mem <= *_ex.
- flush and stall both high: flush wins.
- X/undriven *_ex inputs are passed through unchanged; no sanitising.
- All fields are captured together as one bundle. No per-field enables.

Decomposition:
- Shared package (cpu_pkg):
  - XLEN and REG_AW constants.
  - Typedef for the 2-bit next_pc_selector encoding (SEQ=0, JAL, JALR, BRANCH).
  - Packed struct ex_mem_bundle_t grouping all twelve fields.
- Single flat module; no sub-module needed. Optionally a generic pipe_reg (width parameter; rst/flush/stall) can be reused by the other stage registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with non-zero values held -> all *_mem read 0 before the next clk edge. Release rst -> 0 until the first rising edge.
- Pass-through: drive pc_ex=0x0000_1000, pc_plus_4_ex=0x0000_1004, rd_ex=5, load_ex=1, alu_data_ex=0xDEAD_BEEF -> identical values on *_mem after one rising edge; unchanged before it.
- Random streaming: 5 sets of random inputs changed at non-edge-aligned times (25 ns period stimulus vs 20 ns clock) -> each *_mem equals the *_ex value sampled at the most recent rising edge.
- Stall: load rd_ex=7, then stall=1 while rd_ex=9 and alu_data_ex=0x1234 -> rd_mem stays 7 and alu_data_mem keeps its old value for every stalled cycle. Release stall -> 9 and 0x1234 appear one edge later.
- Flush: with store_ex=1, next_pc_selector_ex=2, rd_ex=3, assert flush -> after the edge all *_mem = 0.
- Flush+stall together: both asserted -> outputs become 0, confirming flush priority.
